stdp_array: RTL

Multi-channel pair-based STDP learning block: N_PRE pre-synaptic inputs converge on one post-synaptic neuron, each with its own saturating weight. It supports both potentiation (pre before post) and depression (post before pre), with an exponential-like magnitude decay and a finite learning window. It sits between the spike sources and the neuron integrator and supplies the synaptic weights the integrator consumes.

---
 rtl/stdp_pkg.sv | 35 +++
 rtl/stdp_timer.sv | 23 ++
 rtl/stdp_array.sv | 113 +++++++++++
 3 files changed

// File: rtl/stdp_pkg.sv
// stdp_pkg: shared constants and arithmetic helpers for the STDP learning array.
// Holds the update-direction encoding plus the decay and saturating add/sub functions.
package stdp_pkg;

    localparam logic DIR_LTP = 1'b1;
    localparam logic DIR_LTD = 1'b0;

    // Step magnitude halves every 2^tau_shift cycles of dt; large shifts collapse to zero.
    function automatic int unsigned decay_step(input int unsigned amp,
                                               input int unsigned dt,
                                               input int unsigned tau_shift);
        int unsigned k;
        k = dt >> tau_shift;
        return (k >= 32) ? 32'd0 : (amp >> k);
    endfunction

    // Add with upper clamp; computed wide enough that the sum never wraps.
    function automatic int unsigned sat_add(input int unsigned w,
                                            input int unsigned dw,
                                            input int unsigned w_max);
        longint signed sum;
        sum = longint'(w) + longint'(dw);
        return (sum > longint'(w_max)) ? w_max : 32'(sum);
    endfunction

    // Subtract with lower clamp; signed so an underflow shows up as a negative value.
    function automatic int unsigned sat_sub(input int unsigned w,
                                            input int unsigned dw,
                                            input int unsigned w_min);
        longint signed diff;
        diff = longint'(w) - longint'(dw);
        return (diff < longint'(w_min)) ? w_min : 32'(diff);
    endfunction

endpackage

// File: rtl/stdp_timer.sv
// stdp_timer: saturating cycles-since-last-spike counter.
// A spike reloads 0; otherwise the count climbs and sticks at all-ones.
module stdp_timer #(
    parameter int unsigned T_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spike,
    output logic [T_WIDTH-1:0] count
);

    // Reset to all-ones so a fresh timer never looks like a recent spike.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '1;
        end else if (spike) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + T_WIDTH'(1);
        end
    end

endmodule

// File: rtl/stdp_array.sv
// stdp_array: pair-based STDP weights for N_PRE synapses onto one neuron.
// Define STDP_LTD_EN to build the post timer and the depression (LTD) rule;
// without it the weights can only be potentiated and upd_dir reads 1.
module stdp_array
    import stdp_pkg::*;
#(
    parameter int unsigned N_PRE     = 4,
    parameter int unsigned W_WIDTH   = 8,
    parameter int unsigned T_WIDTH   = 8,
    parameter int unsigned T_WIN     = 16,
    parameter int unsigned TAU_SHIFT = 2,
    parameter int unsigned A_PLUS    = 16,
    parameter int unsigned A_MINUS   = 8,
    parameter int unsigned W_INIT    = 64,
    parameter int unsigned W_MIN     = 0,
    parameter int unsigned W_MAX     = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_PRE-1:0]           pre_spike,
    input  logic                       post_spike,
    output logic [N_PRE*W_WIDTH-1:0]   weight,
    output logic [N_PRE-1:0]           upd_valid,
    output logic [N_PRE-1:0]           upd_dir
);

    logic [T_WIDTH-1:0] pre_t [N_PRE];

    for (genvar i = 0; i < N_PRE; i++) begin : g_pre_timer
        stdp_timer #(.T_WIDTH(T_WIDTH)) u_timer (
            .clk   (clk),
            .rst_n (rst_n),
            .spike (pre_spike[i]),
            .count (pre_t[i])
        );
    end

`ifdef STDP_LTD_EN
    logic [T_WIDTH-1:0] post_t;

    stdp_timer #(.T_WIDTH(T_WIDTH)) u_post_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (post_spike),
        .count (post_t)
    );
`else
    localparam int unsigned unused_ltd_cfg = A_MINUS + W_MIN;
    assign upd_dir = '1;
`endif

    for (genvar i = 0; i < N_PRE; i++) begin : g_ch
        logic [W_WIDTH-1:0] w_q;
        logic [W_WIDTH-1:0] w_next;
        logic               fire;
        logic               ltp;
        logic               valid_q;
        int unsigned        dw_p;
`ifdef STDP_LTD_EN
        int unsigned        dw_m;
        logic               dir_q;
`endif

        // Rule selection: pre-then-post potentiates, post-then-pre depresses; coincidence does neither.
        always_comb begin
            fire   = 1'b0;
            ltp    = 1'b0;
            w_next = w_q;
            dw_p   = decay_step(A_PLUS, 32'(pre_t[i]), TAU_SHIFT);
`ifdef STDP_LTD_EN
            dw_m   = decay_step(A_MINUS, 32'(post_t), TAU_SHIFT);
`endif
            if (en && post_spike && !pre_spike[i] && (32'(pre_t[i]) < T_WIN) && (dw_p != 0)) begin
                fire   = 1'b1;
                ltp    = 1'b1;
                w_next = W_WIDTH'(sat_add(32'(w_q), dw_p, W_MAX));
            end
`ifdef STDP_LTD_EN
            else if (en && pre_spike[i] && !post_spike && (32'(post_t) < T_WIN) && (dw_m != 0)) begin
                fire   = 1'b1;
                w_next = W_WIDTH'(sat_sub(32'(w_q), dw_m, W_MIN));
            end
`endif
        end

        // Weight register and one-cycle update pulse, landing on the edge that sees the spike.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                w_q     <= W_WIDTH'(W_INIT);
                valid_q <= 1'b0;
`ifdef STDP_LTD_EN
                dir_q   <= DIR_LTD;
`endif
            end else begin
                if (fire) begin
                    w_q <= w_next;
                end
                valid_q <= fire;
`ifdef STDP_LTD_EN
                dir_q   <= ltp ? DIR_LTP : DIR_LTD;
`endif
            end
        end

        assign weight[i*W_WIDTH +: W_WIDTH] = w_q;
        assign upd_valid[i]                 = valid_q;
`ifdef STDP_LTD_EN
        assign upd_dir[i]                   = dir_q;
`endif
    end

endmodule
